// File: rtl/lsu_access_seq.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_access_seq
//  Description : Sequencer between the core memory-stage request port and the
//                lsu datapath. Turns one byte/half/word load or store into one
//                or two word-aligned lsu accesses, drives lsu byte lanes, and
//                aligns and extends load data. One response per request.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional build macro: MISALIGN_TRAP_EN
//     defined   - non-naturally-aligned half/word requests return err=1
//                 without touching the lsu
//     undefined - misaligned requests are split into two accesses
// ----------------------------------------------------------------------------
//  Ports
//     i_clk, i_rst        clock, synchronous active-low reset
//     i_req_*             request: valid, we, size, uns, addr, wdata
//     o_req_ready         request accepted (IDLE only)
//     o_rsp_valid/rdata/err  one-cycle response pulse
//     o_busy              sequencer not IDLE
//     o_lsu_*             word-aligned lsu access: addr, wren, lane mask, data
//     i_lsu_ld_data       raw lsu read word (same-cycle read)
// ============================================================================
module lsu_access_seq #(
   parameter int ADDR_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [1:0]        i_req_size,
   input  logic              i_req_uns,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [31:0]       i_req_wdata,
   output logic              o_rsp_valid,
   output logic [31:0]       o_rsp_rdata,
   output logic              o_rsp_err,
   output logic              o_busy,
   output logic [ADDR_W-1:0] o_lsu_addr,
   output logic              o_lsu_wren,
   output logic [3:0]        o_lsu_num_byte,
   output logic [31:0]       o_lsu_st_data,
   input  logic [31:0]       i_lsu_ld_data
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC0 = 2'd1,
      S_ACC1 = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next;

   logic                r_we;
   logic [1:0]          r_size;
   logic                r_uns;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic [31:0]         r_lo;
   logic [31:0]         r_hi;
   logic                r_err;

   logic                w_accept;
   logic                w_req_bad;
   logic [1:0]          w_off;
   logic [3:0]          w_base;
   logic [7:0]          w_mask8;
   logic [63:0]         w_wide;
   logic                w_cross;
   logic [31:0]         w_raw;
   logic [31:0]         w_ext;
   logic [ADDR_W-3:0]   w_word_nxt;
   logic                w_wren;

   assign w_accept = i_req_valid && (r_state == S_IDLE);

`ifdef MISALIGN_TRAP_EN
   assign w_req_bad = (i_req_size == 2'b11)
                   || ((i_req_size == 2'b01) && i_req_addr[0])
                   || ((i_req_size == 2'b10) && (i_req_addr[1:0] != 2'b00));
`else
   assign w_req_bad = (i_req_size == 2'b11);
`endif

   // Lane geometry of the latched request; bits [7:4] of the mask and the
   // upper word of w_wide belong to the following word.
   assign w_off = r_addr[1:0];

   always_comb begin
      w_base = 4'b1111;
      case (r_size)
         2'b00:   w_base = 4'b0001;
         2'b01:   w_base = 4'b0011;
         default: w_base = 4'b1111;
      endcase
   end

   assign w_mask8    = {4'b0000, w_base} << w_off;
   assign w_wide     = {32'h0, r_wdata} << {w_off, 3'b000};
   assign w_cross    = |w_mask8[7:4];
   assign w_raw      = 32'({r_hi, r_lo} >> {w_off, 3'b000});
   // Word index increments modulo the address space, so 0xFFFFFFFC wraps to 0.
   assign w_word_nxt = r_addr[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1};

   always_comb begin
      w_ext = w_raw;
      case (r_size)
         2'b00:   w_ext = r_uns ? {24'h0, w_raw[7:0]}  : {{24{w_raw[7]}},  w_raw[7:0]};
         2'b01:   w_ext = r_uns ? {16'h0, w_raw[15:0]} : {{16{w_raw[15]}}, w_raw[15:0]};
         default: w_ext = w_raw;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_we    <= 1'b0;
         r_size  <= 2'b00;
         r_uns   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= 32'h0;
         r_lo    <= 32'h0;
         r_hi    <= 32'h0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_we    <= i_req_we;
            r_size  <= i_req_size;
            r_uns   <= i_req_uns;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_err   <= w_req_bad;
            r_hi    <= 32'h0;   // stays zero for non-crossing loads
         end
         if (r_state == S_ACC0) r_lo <= i_lsu_ld_data;
         if (r_state == S_ACC1) r_hi <= i_lsu_ld_data;
      end
   end

   always_comb begin
      w_next         = r_state;
      o_req_ready    = 1'b0;
      o_busy         = 1'b1;
      o_rsp_valid    = 1'b0;
      o_rsp_rdata    = 32'h0;
      o_rsp_err      = 1'b0;
      o_lsu_addr     = '0;
      w_wren         = 1'b0;
      o_lsu_num_byte = 4'b0000;
      o_lsu_st_data  = 32'h0;
      case (r_state)
         S_IDLE: begin
            o_req_ready = 1'b1;
            o_busy      = 1'b0;
            if (w_accept) w_next = w_req_bad ? S_RESP : S_ACC0;
         end
         S_ACC0: begin
            o_lsu_addr     = {r_addr[ADDR_W-1:2], 2'b00};
            w_wren         = r_we;
            o_lsu_num_byte = r_we ? w_mask8[3:0] : 4'b1111;
            o_lsu_st_data  = r_we ? w_wide[31:0] : 32'h0;
            w_next         = w_cross ? S_ACC1 : S_RESP;
         end
         S_ACC1: begin
            o_lsu_addr     = {w_word_nxt, 2'b00};
            w_wren         = r_we;
            o_lsu_num_byte = r_we ? w_mask8[7:4] : 4'b1111;
            o_lsu_st_data  = r_we ? w_wide[63:32] : 32'h0;
            w_next         = S_RESP;
         end
         S_RESP: begin
            o_rsp_valid = 1'b1;
            o_rsp_err   = r_err;
            o_rsp_rdata = (r_we || r_err) ? 32'h0 : w_ext;
            w_next      = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // A reset cycle must not commit the store of an aborted access.
   assign o_lsu_wren = w_wren && i_rst;

endmodule
`default_nettype wire

// File: tb/tb_lsu_access_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_access_seq
//  Description : Self-checking bench for lsu_access_seq: a 16-word lsu memory
//                model, a table of directed request vectors and hand-written
//                multi-cycle sequences (reset abort, crossing store, wrap).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_access_seq;

   localparam int ADDR_W = 32;

   logic              clk;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_uns;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;
   logic              busy;
   logic [ADDR_W-1:0] lsu_addr;
   logic              lsu_wren;
   logic [3:0]        lsu_num_byte;
   logic [31:0]       lsu_st_data;
   logic [31:0]       lsu_ld_data;

   lsu_access_seq #(.ADDR_W(ADDR_W)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_req_valid    (req_valid),
      .o_req_ready    (req_ready),
      .i_req_we       (req_we),
      .i_req_size     (req_size),
      .i_req_uns      (req_uns),
      .i_req_addr     (req_addr),
      .i_req_wdata    (req_wdata),
      .o_rsp_valid    (rsp_valid),
      .o_rsp_rdata    (rsp_rdata),
      .o_rsp_err      (rsp_err),
      .o_busy         (busy),
      .o_lsu_addr     (lsu_addr),
      .o_lsu_wren     (lsu_wren),
      .o_lsu_num_byte (lsu_num_byte),
      .o_lsu_st_data  (lsu_st_data),
      .i_lsu_ld_data  (lsu_ld_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // lsu memory model: word index {addr[13], addr[4:2]} keeps 0x0000_0000,
   // 0x2000, 0x2004 and 0xFFFF_FFFC in distinct slots.
   logic [31:0] mem [16];
   logic        pl_en;
   logic [3:0]  pl_idx;
   logic [31:0] pl_data;

   function automatic logic [3:0] widx(input logic [31:0] a);
      return {a[13], a[4:2]};
   endfunction

   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_idx] <= pl_data;
      end else if (lsu_wren) begin
         for (int b = 0; b < 4; b++)
            if (lsu_num_byte[b]) mem[widx(lsu_addr)][8*b +: 8] <= lsu_st_data[8*b +: 8];
      end
   end

   assign lsu_ld_data = mem[widx(lsu_addr)];

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic preload(input logic [3:0] idx, input logic [31:0] data);
      @(negedge clk);
      pl_en = 1'b1; pl_idx = idx; pl_data = data;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
      req_valid = 1'b1; req_we = we; req_size = sz; req_uns = uns;
      req_addr = a; req_wdata = wd;
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
      int          exp_nacc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rd, input logic er,
                               input int lat, input int nacc);
      vec_t v;
      v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd;
      v.exp_rd = rd; v.exp_err = er; v.exp_lat = lat; v.exp_nacc = nacc;
      return v;
   endfunction

   // One request; latency counts cycles after the handshake cycle.
   task automatic run_req(input vec_t v, output int lat, output logic [31:0] rd,
                          output logic er, output int nacc);
      @(posedge clk); #1;
      drive(v.we, v.size, v.uns, v.addr, v.wdata);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = -1; rd = 32'h0; er = 1'b0; nacc = 0;
      for (int c = 1; c <= 6 && lat < 0; c++) begin
         @(negedge clk);
         if (lsu_wren || (lsu_num_byte != 4'b0000)) nacc++;
         if (rsp_valid) begin
            lat = c; rd = rsp_rdata; er = rsp_err;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int          lat, nacc, seen;
      logic [31:0] rd;
      logic        er;

      rst = 1'b0; pl_en = 1'b0; pl_idx = 4'h0; pl_data = 32'h0;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_uns = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready",   req_ready,    1'b1);
      chk("rst_busy",    busy,         1'b0);
      chk("rst_rsp",     rsp_valid,    1'b0);
      chk("rst_rdata",   rsp_rdata,    32'h0);
      chk("rst_err",     rsp_err,      1'b0);
      chk("rst_addr",    lsu_addr,     32'h0);
      chk("rst_wren",    lsu_wren,     1'b0);
      chk("rst_nbyte",   lsu_num_byte, 4'h0);
      chk("rst_stdata",  lsu_st_data,  32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < 16; i++) preload(4'(i), 32'h0);

`ifndef MISALIGN_TRAP_EN
      // Reset during the second half of a crossing store.
      @(posedge clk); #1;
      drive(1'b1, 2'b10, 1'b0, 32'h2002, 32'hAABBCCDD);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("ra_acc0_wren",  lsu_wren,     1'b1);
      chk("ra_acc0_nbyte", lsu_num_byte, 4'b1100);
      chk("ra_acc0_data",  lsu_st_data,  32'hCCDD0000);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ra_acc1_busy",  busy,     1'b1);
      chk("ra_acc1_wren",  lsu_wren, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      seen = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
         if (c == 0) begin
            chk("ra_ready", req_ready, 1'b1);
            chk("ra_wren",  lsu_wren,  1'b0);
         end
      end
      chk("ra_no_rsp",  seen,   0);
      chk("ra_mem2000", mem[8], 32'hCCDD0000);
      chk("ra_mem2004", mem[9], 32'h00000000);

      // Crossing word store.
      @(posedge clk); #1;
      drive(1'b1, 2'b10, 1'b0, 32'h2003, 32'h11223344);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("cs_acc0_addr",  lsu_addr,     32'h2000);
      chk("cs_acc0_nbyte", lsu_num_byte, 4'b1000);
      chk("cs_acc0_data",  lsu_st_data,  32'h44000000);
      chk("cs_acc0_rsp",   rsp_valid,    1'b0);
      @(negedge clk);
      chk("cs_acc1_addr",  lsu_addr,     32'h2004);
      chk("cs_acc1_nbyte", lsu_num_byte, 4'b0111);
      chk("cs_acc1_data",  lsu_st_data,  32'h00112233);
      chk("cs_acc1_rsp",   rsp_valid,    1'b0);
      @(negedge clk);
      chk("cs_rsp",        rsp_valid,    1'b1);
      chk("cs_rdata",      rsp_rdata,    32'h0);
      chk("cs_err",        rsp_err,      1'b0);
      chk("cs_mem2000",    mem[8],       32'h44DD0000);
      chk("cs_mem2004",    mem[9],       32'h00112233);

      // Address wrap, with a second request held valid while busy.
      preload(4'd15, 32'hA1B2C3D4);
      preload(4'd0,  32'h00005566);
      preload(4'd9,  32'h000000C7);
      @(posedge clk); #1;
      drive(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0);
      @(posedge clk); #1;
      drive(1'b0, 2'b00, 1'b1, 32'h2004, 32'h0);
      @(negedge clk);
      chk("wr_acc0_addr", lsu_addr,  32'hFFFFFFFC);
      chk("wr_acc0_rdy",  req_ready, 1'b0);
      @(negedge clk);
      chk("wr_acc1_addr", lsu_addr,  32'h00000000);
      @(negedge clk);
      chk("wr_rsp",       rsp_valid, 1'b1);
      chk("wr_rdata",     rsp_rdata, 32'h5566A1B2);
      chk("wr_resp_rdy",  req_ready, 1'b0);
      @(negedge clk);
      chk("hold_idle_rdy", req_ready, 1'b1);
      chk("hold_idle_bsy", busy,      1'b0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("hold_acc0_addr", lsu_addr, 32'h2004);
      @(negedge clk);
      chk("hold_rsp",   rsp_valid, 1'b1);
      chk("hold_rdata", rsp_rdata, 32'h000000C7);
`endif

      preload(4'd8, 32'h80FFEEDD);
      preload(4'd9, 32'h00000099);

`ifndef MISALIGN_TRAP_EN
      tbl.push_back(mk(0, 2'b01, 0, 32'h2003, 0, 32'hFFFF9980, 0, 3, 2));
      tbl.push_back(mk(0, 2'b01, 1, 32'h2003, 0, 32'h00009980, 0, 3, 2));
      tbl.push_back(mk(0, 2'b10, 0, 32'h2002, 0, 32'h009980FF, 0, 3, 2));
      tbl.push_back(mk(0, 2'b00, 0, 32'h2003, 0, 32'hFFFFFF80, 0, 2, 1));
      tbl.push_back(mk(0, 2'b00, 1, 32'h2001, 0, 32'h000000EE, 0, 2, 1));
      tbl.push_back(mk(0, 2'b01, 0, 32'h2001, 0, 32'hFFFFFFEE, 0, 2, 1));
      tbl.push_back(mk(1, 2'b10, 0, 32'h2004, 32'hDEADBEEF, 32'h0, 0, 2, 1));
      tbl.push_back(mk(0, 2'b00, 0, 32'h2007, 0, 32'hFFFFFFDE, 0, 2, 1));
      tbl.push_back(mk(0, 2'b00, 1, 32'h2007, 0, 32'h000000DE, 0, 2, 1));
      tbl.push_back(mk(0, 2'b10, 0, 32'h2004, 0, 32'hDEADBEEF, 0, 2, 1));
      tbl.push_back(mk(1, 2'b00, 0, 32'h2005, 32'h00000012, 32'h0, 0, 2, 1));
      tbl.push_back(mk(0, 2'b01, 1, 32'h2004, 0, 32'h000012EF, 0, 2, 1));
      tbl.push_back(mk(1, 2'b01, 0, 32'h2003, 32'h0000A55A, 32'h0, 0, 3, 2));
      tbl.push_back(mk(0, 2'b10, 0, 32'h2002, 0, 32'h12A55AFF, 0, 3, 2));
      tbl.push_back(mk(0, 2'b11, 0, 32'h2000, 0, 32'h0, 1, 1, 0));
      tbl.push_back(mk(1, 2'b11, 0, 32'h2001, 32'hFFFFFFFF, 32'h0, 1, 1, 0));
      tbl.push_back(mk(0, 2'b10, 0, 32'h2000, 0, 32'h5AFFEEDD, 0, 2, 1));
`else
      tbl.push_back(mk(0, 2'b10, 0, 32'h2001, 0, 32'h0, 1, 1, 0));
      tbl.push_back(mk(0, 2'b01, 0, 32'h2003, 0, 32'h0, 1, 1, 0));
      tbl.push_back(mk(0, 2'b01, 0, 32'h2002, 0, 32'hFFFF80FF, 0, 2, 1));
      tbl.push_back(mk(0, 2'b00, 0, 32'h2003, 0, 32'hFFFFFF80, 0, 2, 1));
      tbl.push_back(mk(1, 2'b10, 0, 32'h2002, 32'h00000001, 32'h0, 1, 1, 0));
      tbl.push_back(mk(1, 2'b01, 0, 32'h2001, 32'h0000FFFF, 32'h0, 1, 1, 0));
      tbl.push_back(mk(0, 2'b10, 0, 32'h2004, 0, 32'h00000099, 0, 2, 1));
      tbl.push_back(mk(0, 2'b10, 0, 32'h2000, 0, 32'h80FFEEDD, 0, 2, 1));
      tbl.push_back(mk(0, 2'b11, 0, 32'h2000, 0, 32'h0, 1, 1, 0));
`endif

      foreach (tbl[i]) begin
         run_req(tbl[i], lat, rd, er, nacc);
         chk($sformatf("v%0d_lat",   i), lat,  tbl[i].exp_lat);
         chk($sformatf("v%0d_rdata", i), rd,   tbl[i].exp_rd);
         chk($sformatf("v%0d_err",   i), er,   tbl[i].exp_err);
         chk($sformatf("v%0d_nacc",  i), nacc, tbl[i].exp_nacc);
      end

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lsu_access_seq.md
Name: lsu_access_seq

Overview:
- Sequencer between the core's memory-stage request port and the lsu datapath.
- Accepts one byte, half or word load/store at a time and converts it into one or two word-aligned lsu accesses. Two accesses are needed when the access crosses a 4-byte boundary.
- Drives lsu byte lanes directly and performs load byte-alignment and sign/zero extension itself.
- Returns a single response per request; the core stalls on o_req_ready low.

Parameters:
- ADDR_W, 32, width of request/lsu address.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-low
- i_req_valid  in  1  request present
- o_req_ready  out  1  sequencer can accept (IDLE only)
- i_req_we  in  1  1=store, 0=load
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- i_req_uns  in  1  zero-extend load (LBU/LHU)
- i_req_addr  in  ADDR_W  byte address
- i_req_wdata  in  32  store data, right-justified
- o_rsp_valid  out  1  one-cycle response pulse
- o_rsp_rdata  out  32  extended load data (0 for stores/errors)
- o_rsp_err  out  1  illegal size (valid with o_rsp_valid)
- o_busy  out  1  not IDLE
- o_lsu_addr  out  ADDR_W  word-aligned address to lsu (bits[1:0]=00)
- o_lsu_wren  out  1  lsu store enable
- o_lsu_num_byte  out  4  lsu byte-lane mask
- o_lsu_st_data  out  32  lane-positioned store data
- i_lsu_ld_data  in  32  raw word from lsu (async read, valid same cycle as address)

Behaviour:
- States: IDLE, ACC0, ACC1, RESP.
- Reset (i_rst=0 at posedge) → IDLE. All outputs 0 except o_req_ready=1. Reset in any state aborts the access with no response. The lsu write for that cycle still occurs only if reset was not asserted in it.
- IDLE: o_req_ready=1. Handshake on i_req_valid & o_req_ready: latch we, size, uns, addr, wdata.
  - Size 11 → RESP with err=1, no lsu access.
  - Otherwise → ACC0.
- Offset off=addr[1:0]. n = 1/2/4 bytes for size 00/01/10.
- Store lanes: mask8 = ((1<<n)-1) << off (8 bits). wide = {32'b0, wdata} << (8*off) (64 bits). cross = |mask8[7:4].
- ACC0 (one cycle):
  - o_lsu_addr = {addr[ADDR_W-1:2], 2'b00}.
  - Store: wren=1, num_byte=mask8[3:0], st_data=wide[31:0].
  - Load: wren=0, num_byte=1111.
  - Capture i_lsu_ld_data into lo.
  - cross → ACC1, else → RESP.
- ACC1 (one cycle):
  - o_lsu_addr = {addr[ADDR_W-1:2]+1, 2'b00}; wraps to 0 from 0xFFFFFFFC.
  - Store: wren=1, num_byte=mask8[7:4], st_data=wide[63:32].
  - Load: wren=0, num_byte=1111.
  - Capture hi. → RESP.
- RESP (one cycle): o_rsp_valid=1; → IDLE.
  - Load: raw = ({hi, lo} >> 8*off)[31:0]. hi=0 if no cross.
  - Size 00: ext of raw[7:0]. Size 01: ext of raw[15:0]. Size 10: raw.
  - ext = zero if uns, else sign.
  - Store: rdata=0.
- In ACC0/ACC1/RESP: o_req_ready=0, o_busy=1. Requests are ignored (not latched) until IDLE.
- Outside ACC0/ACC1: wren=0, num_byte=0000, o_lsu_addr=0, st_data=0.
- Latency, handshake to o_rsp_valid:
  - Aligned or non-crossing: 2 cycles.
  - Crossing: 3 cycles.
  - Illegal size: 1 cycle.
- Back-to-back: next accept is the cycle after RESP. Minimum request spacing is 3 cycles.
- No response backpressure; the core must sample o_rsp_valid.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - Any non-naturally-aligned request goes IDLE→RESP with err=1 and no lsu access. Non-naturally-aligned means half with addr[0]=1, or word with addr[1:0]≠00.
  - ACC1 is unreachable and may be omitted.
- Undefined: misaligned accesses are split as above; err only for size 11.

Test Plan:
- Reset mid-access: store word at 0x2002, assert i_rst=0 during ACC1 → no rsp. Only first half written: mem[0x2000] bytes 2,3 changed. o_lsu_wren=0 next cycle; o_req_ready=1 after reset.
- Aligned store/load:
  - SW 0x2004 ← 0xDEADBEEF → one access, num_byte=1111, rsp at +2.
  - LB 0x2007 → rdata 0xFFFFFFDE; LBU → 0x000000DE.
- Crossing store: SW 0x2003 ← 0x11223344.
  - ACC0: addr 0x2000, mask 1000, st_data 0x44000000.
  - ACC1: addr 0x2004, mask 0111, st_data 0x00112233.
  - rsp at +3.
- Crossing load: mem 0x2000=0x80FFEEDD, 0x2004=0x00000099.
  - LH 0x2003 → two accesses, rdata 0xFFFF9980.
  - LHU 0x2003 → 0x00009980.
- Illegal size: size=11 → rsp at +1, err=1, o_lsu_wren never asserted.
  - With MISALIGN_TRAP_EN: LW 0x2001 → err=1, no lsu access.
- Wrap: LW 0xFFFFFFFE → ACC1 o_lsu_addr=0x00000000. Request held during busy is accepted only after RESP.
